// File: rtl/mips_predecode_queue.sv
// mips_predecode_queue: instruction queue that predecodes each fetched MIPS word on entry
module mips_predecode_queue #(
  parameter int DEPTH = 8,
  parameter int IN_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [32*IN_W-1:0]       in_inst,
  input  logic [IN_W-1:0]          in_mask,
  input  logic [63:0]              in_pc,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_inst,
  output logic [63:0]              out_pc,
  output logic [2:0]               out_class,
  output logic                     out_link,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [31:0]   r_inst [DEPTH];
  logic [63:0]   r_pc   [DEPTH];
  logic [2:0]    r_cls  [DEPTH];
  logic          r_link [DEPTH];
  logic [AW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_pop;
  logic [AW-1:0] w_addr [IN_W];
  logic          w_enq, w_deq;
  function automatic logic [3:0] f_pd(input logic [5:0] op, input logic [9:0] rsrt,
                                      input logic [4:0] rd, input logic [5:0] fn);
    logic       bal, jalr;
    logic [2:0] c;
    bal  = op == 6'b000001 && rsrt == 10'b00000_10001;
    jalr = op == 6'b000000 && fn == 6'b001001;
    case (op)
      6'b100000, 6'b100001, 6'b100011, 6'b100100,
      6'b100101, 6'b100111, 6'b110111:            c = 3'd1;
      6'b101000, 6'b101001, 6'b101011, 6'b111111: c = 3'd2;
      6'b000100, 6'b000101, 6'b110010:            c = 3'd3;
      6'b000001:                                  c = bal ? 3'd3 : 3'd0;
      6'b000010, 6'b000011:                       c = 3'd4;
      6'b010000:                                  c = 3'd5;
      6'b000000: c = (fn == 6'b001000 || fn == 6'b001001) ? 3'd4 :
                     (fn == 6'b001100 || fn == 6'b001101) ? 3'd6 : 3'd0;
      default:                                    c = 3'd0;
    endcase
    return {op == 6'b000011 || bal || (jalr && rd != 5'd0), c};
  endfunction
  assign in_ready  = (CW'(DEPTH) - r_count) >= CW'(IN_W);
  assign w_enq     = in_valid && in_ready && !flush;
  assign w_deq     = out_valid && out_ready && !flush;
  assign out_valid = r_count != '0;
  assign out_inst  = out_valid ? r_inst[r_head] : '0;
  assign out_pc    = out_valid ? r_pc[r_head]   : '0;
  assign out_class = out_valid ? r_cls[r_head]  : '0;
  assign out_link  = out_valid && r_link[r_head];
  assign count     = r_count;
  // slot for each lane is the tail plus the number of valid lanes below it
  always_comb begin
    w_pop = '0;
    for (int k = 0; k < IN_W; k++) begin
      w_addr[k] = r_tail + w_pop[AW-1:0];
      w_pop = w_pop + CW'(in_mask[k]);
    end
  end
  // store valid lanes compacted, with their own PC and predecode
  always_ff @(posedge clk)
    for (int k = 0; k < IN_W; k++)
      if (w_enq && in_mask[k]) begin
        r_inst[w_addr[k]] <= in_inst[32*k +: 32];
        r_pc[w_addr[k]]   <= in_pc + 64'(4 * k);
        {r_link[w_addr[k]], r_cls[w_addr[k]]} <= f_pd(in_inst[32*k+26 +: 6], in_inst[32*k+16 +: 10],
                                                      in_inst[32*k+11 +: 5], in_inst[32*k +: 6]);
      end
  // pointers and occupancy; reset beats flush, flush beats enqueue/dequeue
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + w_pop[AW-1:0];
      if (w_deq) r_head <= r_head + 1'b1;
      r_count <= r_count + (w_enq ? w_pop : CW'(0)) - CW'(w_deq);
    end
  end
endmodule

// File: tb/tb_mips_predecode_queue.sv
// tb_mips_predecode_queue: scoreboard bench for the predecode queue at DEPTH=4, IN_W=2
module tb_mips_predecode_queue;
  localparam int DEPTH = 4;
  localparam int IN_W  = 2;
  localparam int NT    = 17;
  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [2:0]  cls;
    logic        link;
  } ent_t;
  logic        clk = 0, rst_n = 0, in_valid = 0, flush = 0, out_ready = 0;
  logic        in_ready, out_valid, out_link;
  logic [63:0] in_inst = '0, in_pc = '0, out_pc;
  logic [1:0]  in_mask = '0;
  logic [31:0] out_inst;
  logic [2:0]  out_class, count;
  ent_t        sb[$];
  ent_t        exp_e, obs, held;
  int          tests = 0, fails = 0;
  logic [31:0] t_inst [NT];
  logic [2:0]  t_cls  [NT];
  logic        t_link [NT];

  mips_predecode_queue #(.DEPTH(DEPTH), .IN_W(IN_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_mask(in_mask), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .out_class(out_class), .out_link(out_link), .count(count));

  always #5 clk = ~clk;
  assign obs = {out_inst, out_pc, out_class, out_link};

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [1:0] m, input int a, input int b, input logic [63:0] pc);
    in_valid = 1; in_mask = m; in_inst = {t_inst[b], t_inst[a]}; in_pc = pc;
    if (m[0]) sb.push_back({t_inst[a], pc, t_cls[a], t_link[a]});
    if (m[1]) sb.push_back({t_inst[b], pc + 64'd4, t_cls[b], t_link[b]});
    step;
    in_valid = 0; in_mask = 0;
  endtask

  task automatic test_reset;
    rst_n = 0; step; step; rst_n = 1;
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", count); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    tests++; if (obs !== '0) begin fails++; $display("FAIL reset_outputs_zero: got %h expected 0", obs); end
  endtask

  task automatic test_basic;
    enq(2'b11, 0, 1, 64'h1000);
    tests++; if (count !== 3'd2) begin fails++; $display("FAIL basic_count: got %0d expected 2", count); end
    for (int i = 0; i < 2; i++) begin
      exp_e = sb.pop_front();
      tests++; if (obs !== exp_e) begin fails++; $display("FAIL basic_head%0d: got %h expected %h", i, obs, exp_e); end
      out_ready = 1; step; out_ready = 0;
    end
    tests++; if (out_valid !== 1'b0 || obs !== '0) begin fails++; $display("FAIL basic_empty: got valid=%b %h expected 0", out_valid, obs); end
  endtask

  task automatic test_mask;
    enq(2'b10, 8, 2, 64'h2000);
    tests++; if (count !== 3'd1) begin fails++; $display("FAIL mask_count: got %0d expected 1", count); end
    in_valid = 1; in_mask = 2'b00; in_inst = {t_inst[0], t_inst[3]}; step; in_valid = 0;
    tests++; if (count !== 3'd1) begin fails++; $display("FAIL mask_zero_count: got %0d expected 1", count); end
    exp_e = sb.pop_front();
    tests++; if (obs !== exp_e) begin fails++; $display("FAIL mask_head: got %h expected %h", obs, exp_e); end
    out_ready = 1; step; out_ready = 0;
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL mask_drain: got %0d expected 0", count); end
  endtask

  task automatic test_full;
    enq(2'b11, 3, 4, 64'h3000);
    enq(2'b01, 5, 0, 64'h3010);
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
    held = obs;
    in_valid = 1; in_mask = 2'b11; in_inst = {t_inst[6], t_inst[6]}; step; in_valid = 0;
    tests++; if (count !== 3'd3) begin fails++; $display("FAIL full_blocked_count: got %0d expected 3", count); end
    tests++; if (obs !== held) begin fails++; $display("FAIL full_head_stable: got %h expected %h", obs, held); end
    exp_e = sb.pop_front();
    tests++; if (obs !== exp_e) begin fails++; $display("FAIL full_head0: got %h expected %h", obs, exp_e); end
    out_ready = 1; step; out_ready = 0;
    tests++; if (count !== 3'd2 || in_ready !== 1'b1) begin fails++; $display("FAIL full_reopen: got count=%0d ready=%b expected 2/1", count, in_ready); end
    exp_e = sb.pop_front();
    tests++; if (obs !== exp_e) begin fails++; $display("FAIL full_head1: got %h expected %h", obs, exp_e); end
    out_ready = 1;
    enq(2'b11, 6, 7, 64'h3020);
    out_ready = 0;
    tests++; if (count !== 3'd3) begin fails++; $display("FAIL full_simul: got %0d expected 3", count); end
    for (int i = 0; i < 8 && sb.size() > 0; i++) begin
      exp_e = sb.pop_front();
      tests++; if (obs !== exp_e) begin fails++; $display("FAIL full_drain%0d: got %h expected %h", i, obs, exp_e); end
      out_ready = 1; step; out_ready = 0;
    end
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL full_empty: got %0d expected 0", count); end
  endtask

  task automatic test_stream;
    int g = 0;
    int a, b;
    logic [63:0] pc;
    for (int cyc = 0; cyc < 300 && (g < 10 || sb.size() > 0); cyc++) begin
      out_ready = (cyc % 3) != 0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++; fails++; $display("FAIL stream_extra: got %h expected nothing", obs);
        end else begin
          exp_e = sb.pop_front();
          tests++; if (obs !== exp_e) begin fails++; $display("FAIL stream_order: got %h expected %h", obs, exp_e); end
        end
      end
      if (g < 10 && in_ready) begin
        a = $urandom_range(0, NT - 1); b = $urandom_range(0, NT - 1);
        pc = (g == 4) ? 64'hFFFF_FFFF_FFFF_FFFC : 64'h4000 + 64'(16 * g);
        in_valid = 1; in_mask = 2'($urandom_range(0, 3)); in_inst = {t_inst[b], t_inst[a]}; in_pc = pc;
        if (in_mask[0]) sb.push_back({t_inst[a], pc, t_cls[a], t_link[a]});
        if (in_mask[1]) sb.push_back({t_inst[b], pc + 64'd4, t_cls[b], t_link[b]});
        g++;
      end else in_valid = 0;
      step;
      in_valid = 0;
      tests++; if (int'(count) != sb.size()) begin fails++; $display("FAIL stream_count: got %0d expected %0d", count, sb.size()); end
    end
    out_ready = 0;
    tests++; if (g < 10 || sb.size() > 0) begin fails++; $display("FAIL stream_timeout: got %0d groups %0d pending expected 10/0", g, sb.size()); end
  endtask

  task automatic test_flush;
    enq(2'b11, 0, 1, 64'h5000);
    enq(2'b01, 3, 0, 64'h5010);
    in_valid = 1; in_mask = 2'b11; out_ready = 1; flush = 1; step;
    in_valid = 0; out_ready = 0; flush = 0; sb.delete();
    tests++; if (count !== 3'd0 || out_valid !== 1'b0) begin fails++; $display("FAIL flush_state: got count=%0d valid=%b expected 0/0", count, out_valid); end
    tests++; if (obs !== '0 || in_ready !== 1'b1) begin fails++; $display("FAIL flush_outputs: got %h ready=%b expected 0/1", obs, in_ready); end
    enq(2'b01, 4, 0, 64'h5100);
    in_valid = 1; in_mask = 2'b11; in_inst = {t_inst[5], t_inst[5]}; out_ready = 1; flush = 1; step;
    in_valid = 0; out_ready = 0; flush = 0; sb.delete();
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL flush_enq_suppressed: got %0d expected 0", count); end
    enq(2'b01, 6, 0, 64'h5200);
    exp_e = sb.pop_front();
    tests++; if (obs !== exp_e) begin fails++; $display("FAIL flush_after: got %h expected %h", obs, exp_e); end
    out_ready = 1; step; out_ready = 0;
  endtask

  task automatic test_reset_mid;
    enq(2'b11, 0, 1, 64'h6000);
    enq(2'b11, 3, 4, 64'h6010);
    tests++; if (count !== 3'd4 || in_ready !== 1'b0) begin fails++; $display("FAIL rmid_full: got count=%0d ready=%b expected 4/0", count, in_ready); end
    rst_n = 0; step; rst_n = 1; sb.delete();
    tests++; if (count !== 3'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL rmid_reset: got count=%0d ready=%b valid=%b expected 0/1/0", count, in_ready, out_valid); end
    enq(2'b01, 6, 0, 64'h7000);
    tests++; if (out_class !== 3'd6 || out_link !== 1'b0) begin fails++; $display("FAIL rmid_syscall: got class=%0d link=%b expected 6/0", out_class, out_link); end
    exp_e = sb.pop_front();
    tests++; if (obs !== exp_e) begin fails++; $display("FAIL rmid_head: got %h expected %h", obs, exp_e); end
    out_ready = 1; step; out_ready = 0;
  endtask

  initial begin
    t_inst = '{32'h8C410004, 32'h0C000010, 32'h03E0F809, 32'hAC410004, 32'h10220003, 32'h04110004,
               32'h0000000C, 32'h42000018, 32'h00000000, 32'h03E00008, 32'h03E00009, 32'h04100004,
               32'h0000000D, 32'h08000000, 32'hDC000000, 32'hFC000000, 32'hC8000000};
    t_cls  = '{3'd1, 3'd4, 3'd4, 3'd2, 3'd3, 3'd3, 3'd6, 3'd5, 3'd0, 3'd4, 3'd4, 3'd0,
               3'd6, 3'd4, 3'd1, 3'd2, 3'd3};
    t_link = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    test_reset;
    test_basic;
    test_mask;
    test_full;
    test_stream;
    test_flush;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end
endmodule
